// File: rtl/instr_fetch.sv
// Instruction fetch stage: program memory, PC stepping and valid/ready output to proc.
// Define FETCH_WRAP_EN to let the PC wrap past the last word instead of halting there.
module instr_fetch #(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              start,
    input  logic              clear,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef FETCH_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    logic [31:0]       mem [DEPTH];
    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, pc_out_nx;
    logic [31:0]       instr_nx;
    logic              valid_nx;
    // Set while the word from the last address is on the output and must drain before HALT.
    logic              last_q, last_nx;

    logic [31:0] word;
    logic        advance;
    logic        xfer;
    logic        is_halt;

    assign word    = mem[pc];
    assign advance = !instr_valid || instr_ready;
    assign xfer    = instr_valid && instr_ready;
    assign is_halt = (word[31:24] == HALT_OP);

    // NOTE: the program store has no reset so a loaded program survives rst_n and can be rerun.
    always_ff @(posedge clk) begin
        if (ld_we && state == S_IDLE)
            mem[ld_addr] <= ld_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            last_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instr       <= instr_nx;
            instr_valid <= valid_nx;
            pc_out      <= pc_out_nx;
            last_q      <= last_nx;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        instr_nx  = instr;
        valid_nx  = instr_valid;
        pc_out_nx = pc_out;
        last_nx   = last_q;

        unique case (state)
            S_IDLE: begin
                valid_nx = 1'b0;
                if (start) begin
                    state_nx = S_RUN;
                    pc_nx    = '0;
                    last_nx  = 1'b0;
                end
            end
            S_RUN: begin
                if (jmp_valid) begin
                    pc_nx    = jmp_addr;
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                end else if (last_q) begin
                    if (xfer) begin
                        valid_nx = 1'b0;
                        last_nx  = 1'b0;
                        state_nx = S_HALT;
                    end
                end else if (advance) begin
                    if (is_halt) begin
                        valid_nx = 1'b0;
                        state_nx = S_HALT;
                    end else begin
                        instr_nx  = word;
                        pc_out_nx = pc;
                        valid_nx  = 1'b1;
                        pc_nx     = pc + ADDR_W'(1);
                        last_nx   = !WRAP_EN && (&pc);
                    end
                end
            end
            S_HALT: begin
                valid_nx = 1'b0;
                if (clear)
                    state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-walk model queues expected transfers, a monitor pops them.
module tb_instr_fetch;

    localparam int          ADDR_W  = 4;
    localparam int          DEPTH   = 16;
    localparam logic [7:0]  HALT_OP = 8'hFF;

    logic              clk;
    logic              rst_n;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              start;
    logic              clear;
    logic              jmp_valid;
    logic [ADDR_W-1:0] jmp_addr;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] pc_out;
    logic              busy;
    logic              done;

    instr_fetch #(.ADDR_W(ADDR_W), .HALT_OP(HALT_OP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .start      (start),
        .clear      (clear),
        .jmp_valid  (jmp_valid),
        .jmp_addr   (jmp_addr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_out     (pc_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       w;
        logic [ADDR_W-1:0] pc;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          mon_en  = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) instr_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a[ADDR_W-1:0];
        ld_data = d;
        tick();
        ld_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic push_exp(input int a);
        xfer_t e;
        e.w  = ref_mem[a];
        e.pc = a[ADDR_W-1:0];
        exp_q.push_back(e);
    endtask

    // Walk the program from address 0 until a halt opcode or the last word.
    task automatic expect_run();
        for (int a = 0; a < DEPTH; a++) begin
            if (ref_mem[a][31:24] == HALT_OP) break;
            push_exp(a);
        end
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_done(input int budget, input string name);
        int i = 0;
        while (!done && i < budget) begin
            tick();
            i++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_valid"}, 32'(instr_valid), 32'd0);
    endtask

    // Monitor: every accepted transfer must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_xfer: got instr %h pc %0d, expected no transfer", instr, pc_out);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    check("xfer_instr", instr, e.w);
                    check("xfer_pc", 32'(pc_out), 32'(e.pc));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        clear = 1'b0; jmp_valid = 1'b0; jmp_addr = '0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Basic program, consumer always ready.
        load_word(0, 32'h00033964);
        load_word(1, 32'h01043964);
        load_word(2, 32'h02053903);
        load_word(3, 32'h02063904);
        load_word(4, 32'hFF000000);
        for (int a = 5; a < DEPTH; a++) load_word(a, 32'h0);
        expect_run();
        instr_ready = 1'b1;
        go();
        wait_done(100, "basic");
        start = 1'b1; jmp_valid = 1'b1; jmp_addr = '0;
        tick();
        start = 1'b0; jmp_valid = 1'b0;
        tick();
        check("halt_sticky_done", 32'(done), 32'd1);
        check("halt_sticky_valid", 32'(instr_valid), 32'd0);
        clear_pulse();
        check("clear_done", 32'(done), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);

        // Stall after the first word; last program word written in the same cycle as start.
        load_word(4, 32'h05000000);
        instr_ready = 1'b0;
        ld_we = 1'b1; ld_addr = 4'd4; ld_data = 32'hFF000000; start = 1'b1;
        ref_mem[4] = 32'hFF000000;
        expect_run();
        tick();
        ld_we = 1'b0; start = 1'b0;
        tick();
        check("first_latency_valid", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", instr, 32'h00033964);
            check("stall_pc", 32'(pc_out), 32'd0);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end
        instr_ready = 1'b1;
        wait_done(100, "stall");
        clear_pulse();

        // Redirect while word 1 is accepted: bubble, then resume at address 2.
        for (int a = 0; a < 4; a++) push_exp(a);
        instr_ready = 1'b1;
        go();
        tick();
        tick();
        check("jmp_pending", instr, 32'h01043964);
        jmp_valid = 1'b1; jmp_addr = 4'd2;
        tick();
        jmp_valid = 1'b0;
        check("jmp_bubble", 32'(instr_valid), 32'd0);
        tick();
        check("jmp_target_instr", instr, 32'h02053903);
        check("jmp_target_pc", 32'(pc_out), 32'd2);
        wait_done(100, "jmp");
        clear_pulse();

        // Redirect while word 2 is stalled: it is flushed, fetch restarts at address 1.
        push_exp(0); push_exp(1); push_exp(1); push_exp(2); push_exp(3);
        go();
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        jmp_valid = 1'b1; jmp_addr = 4'd1;
        tick();
        jmp_valid = 1'b0;
        instr_ready = 1'b1;
        check("flush_bubble", 32'(instr_valid), 32'd0);
        wait_done(100, "flush");
        clear_pulse();

        // Load attempts outside IDLE are ignored.
        expect_run();
        instr_ready = 1'b0;
        go();
        tick();
        ld_we = 1'b1; ld_addr = 4'd1; ld_data = 32'hDEADBEEF;
        tick();
        ld_we = 1'b0;
        instr_ready = 1'b1;
        wait_done(100, "ld_run");
        clear_pulse();
        expect_run();
        go();
        wait_done(100, "ld_rerun");
        clear_pulse();

        // Asynchronous reset mid-run, then replay of the retained program.
        expect_run();
        rand_ready = 1'b1;
        go();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_instr", instr, 32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_pc_out", 32'(pc_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        tick();
        expect_run();
        go();
        wait_done(200, "replay");
        clear_pulse();

        // Random programs with random back-pressure.
        for (int k = 0; k < 8; k++) begin
            int halt_at;
`ifdef FETCH_WRAP_EN
            halt_at = int'($urandom_range(0, DEPTH - 1));
`else
            halt_at = int'($urandom_range(0, DEPTH));
`endif
            for (int a = 0; a < DEPTH; a++) begin
                logic [31:0] w;
                w = {8'($urandom_range(0, 254)), 24'($urandom)};
                if (a == halt_at) w[31:24] = HALT_OP;
                load_word(a, w);
            end
            expect_run();
            go();
            wait_done(300, "rand");
            clear_pulse();
        end

        // Full memory of non-halt words: end-of-memory handling.
        rand_ready = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            load_word(a, {8'($urandom_range(0, 254)), 24'($urandom)});
        expect_run();
        instr_ready = 1'b1;
`ifdef FETCH_WRAP_EN
        for (int a = 0; a < 3; a++) push_exp(a);
`endif
        go();
        repeat (16) tick();
        check("end_last_valid", 32'(instr_valid), 32'd1);
        check("end_last_pc", 32'(pc_out), 32'd15);
        check("end_last_done", 32'(done), 32'd0);
        tick();
`ifdef FETCH_WRAP_EN
        check("wrap_pc", 32'(pc_out), 32'd0);
        check("wrap_instr", instr, ref_mem[0]);
        check("wrap_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        mon_en = 1'b0;
        check("wrap_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_still_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
`else
        check("end_done", 32'(done), 32'd1);
        check("end_valid", 32'(instr_valid), 32'd0);
        check("end_drained", 32'(exp_q.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of proc.
- Holds a small program memory loaded over a write port and steps a PC through it.
- Presents one 32-bit instruction per cycle, packed {opcode[31:24], dest[23:16], src1[15:8], src2/imm[7:0]}, behind a valid/ready handshake.
- Supports jump redirect, halt-opcode detection and stall from the consumer.

Parameters:
- ADDR_W, 4, PC/memory address width; memory depth = 2**ADDR_W words.
- HALT_OP, 8'hFF, opcode that stops fetching; never emitted downstream.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- ld_we  input  1  program-load write enable; honoured only in IDLE
- ld_addr  input  ADDR_W  program-load address
- ld_data  input  32  program-load word
- start  input  1  pulse; IDLE->RUN, PC<=0
- clear  input  1  pulse; HALT->IDLE
- jmp_valid  input  1  redirect request; honoured only in RUN
- jmp_addr  input  ADDR_W  redirect target
- instr  output  32  instruction to proc (registered)
- instr_valid  output  1  instr holds a valid instruction
- instr_ready  input  1  consumer accepts instr this cycle
- pc_out  output  ADDR_W  address of the word currently in instr
- busy  output  1  state==RUN
- done  output  1  state==HALT

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=0, instr=0, instr_valid=0, pc_out=0, busy=0, done=0. Memory contents are not reset.
- Memory: 2**ADDR_W x 32 register array.
  - Combinational read at PC.
  - Synchronous write when ld_we && state==IDLE.
  - ld_we outside IDLE is ignored.
- States:
  - IDLE: load allowed; start -> RUN with PC<=0, instr_valid stays 0.
  - RUN: fetch and emit as below.
  - HALT: instr_valid=0; clear -> IDLE. start and jmp_valid are ignored.
- Fetch condition (RUN): advance = !instr_valid || instr_ready.
- Output transfer occurs when instr_valid && instr_ready.
- On advance, with word w = mem[PC]:
  - w[31:24] != HALT_OP: instr<=w, pc_out<=PC, instr_valid<=1, PC<=PC+1.
  - w[31:24] == HALT_OP: instr_valid<=0, state<=HALT, PC unchanged.
  - PC == 2**ADDR_W-1 and word is not halt: emit the word, then end-of-memory handling (see Optional Feature).
- Stall: advance=0 holds instr, instr_valid, pc_out and PC stable.
- Latency:
  - First instruction valid 1 cycle after start is sampled.
  - Sustained throughput is 1 instr/cycle while instr_ready=1.
- Redirect: jmp_valid in RUN has priority over fetch.
  - PC<=jmp_addr, instr_valid<=0 (flushes the pending output even if instr_ready=1 that cycle; that transfer still counts as accepted).
  - Fetch at jmp_addr on the next cycle.
- Simultaneous events:
  - start and ld_we together in IDLE: write completes, state->RUN.
  - clear in RUN is ignored.
- rst_n asserted mid-operation: immediate return to reset values. The program is retained and can be rerun via start.
- PC arithmetic is modulo 2**ADDR_W. jmp_addr is used unmodified.

Optional Feature:
- Macro: FETCH_WRAP_EN.
- Without FETCH_WRAP_EN:
  - After emitting the word at PC == 2**ADDR_W-1, go to HALT once that instruction is accepted.
  - instr_valid stays 1 until the transfer; done asserts the cycle after acceptance.
- With FETCH_WRAP_EN:
  - PC wraps to 0 and fetching continues.
  - Only HALT_OP or reset stops execution.

Test Plan:
- Load addr0..3 = 32'h00033964, 32'h01043964, 32'h02053903, 32'h02063904, addr4 = 32'hFF000000; start; instr_ready=1 -> instr shows the four words on consecutive cycles with pc_out 0..3, then instr_valid=0 and done=1, never 32'hFF000000.
- Same program, instr_ready low for 3 cycles after the first word -> instr holds 32'h00033964 and pc_out=0 stable; sequence resumes without loss or duplication.
- jmp_valid with jmp_addr=2 while instr=32'h01043964 is pending -> instr_valid drops for one cycle, next emitted word is 32'h02053903 with pc_out=2.
- ld_we to addr1 with 32'hDEADBEEF during RUN -> ignored; rerun after clear+start still emits 32'h01043964 at pc_out=1.
- All 16 words non-halt, no macro -> word at pc_out=15 emitted then done=1. With FETCH_WRAP_EN -> next word is pc_out=0 and busy stays 1.
- rst_n pulsed low mid-RUN -> instr=0, instr_valid=0, pc_out=0, busy=0 asynchronously; start afterwards replays from pc_out=0 with the same memory contents.
